// File: rtl/pc_gen.sv
// pc_gen -- fetch-stage program-counter unit.
//
// Holds the architectural fetch PC and picks the next PC from six sources
// with a fixed priority: exception entry, exception return, jump-register,
// jump, taken branch, and sequential. A decode redirect that arrives while
// fetch is stalled is kept in a one-entry pending register. It is applied on
// the first unstalled cycle unless a newer redirect replaces it.
//
// Parameters
//   AW        address width in bits (32 or less)
//   RESET_PC  PC loaded during reset (truncated to AW)
//   EXC_VEC   exception entry address
//   PC_STEP   sequential increment in bytes
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   stall_f                     fetch stall (exc/eret still act while high)
//   br_taken_d, br_target_d     taken branch and its target
//   jump_d, jump_target_d       J/JAL and its target
//   jr_d, jr_target_d           JR/JALR and its register target
//   exc_req, eret_req, epc      exception entry / return and return address
//   pc_f, pc_plus4_f            registered fetch PC and PC + PC_STEP
//   npc                         combinational value of pc_f after the next edge
//   fetch_valid                 0 in reset, 1 from the first edge onward
//   pend_valid                  a buffered redirect is waiting
//   adel_f                      fetch PC is not word aligned
module pc_gen #(
  parameter int          AW       = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
  parameter int          PC_STEP  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall_f,
  input  logic          br_taken_d,
  input  logic [AW-1:0] br_target_d,
  input  logic          jump_d,
  input  logic [AW-1:0] jump_target_d,
  input  logic          jr_d,
  input  logic [AW-1:0] jr_target_d,
  input  logic          exc_req,
  input  logic          eret_req,
  input  logic [AW-1:0] epc,
  output logic [AW-1:0] pc_f,
  output logic [AW-1:0] pc_plus4_f,
  output logic [AW-1:0] npc,
  output logic          fetch_valid,
  output logic          pend_valid,
  output logic          adel_f
);

  localparam logic [AW-1:0] RESET_PC_AW = AW'(RESET_PC);
  localparam logic [AW-1:0] EXC_VEC_AW  = AW'(EXC_VEC);
  localparam logic [AW-1:0] STEP_AW     = AW'(PC_STEP);

  typedef enum logic {RUN, PEND} state_t;

  state_t        state;
  logic [AW-1:0] pend_target;
  logic          dec_redirect;
  logic [AW-1:0] dec_target;

  assign pc_plus4_f = pc_f + STEP_AW;
  assign adel_f     = pc_f[1:0] != 2'b00;
  assign pend_valid = state == PEND;

  // Highest-priority decode redirect and its target (jr > jump > branch).
  always_comb begin
    dec_redirect = jr_d | jump_d | br_taken_d;
    dec_target   = br_target_d;
    if (jr_d)
      dec_target = jr_target_d;
    else if (jump_d)
      dec_target = jump_target_d;
  end

  // Next-PC selection. The first edge after reset only raises fetch_valid,
  // so pc_f keeps RESET_PC for one full cycle. A stall holds the PC against
  // decode redirects but not against exception entry or return.
  always_comb begin
    npc = pc_f;
    if (!fetch_valid)
      npc = pc_f;
    else if (exc_req)
      npc = EXC_VEC_AW;
    else if (eret_req)
      npc = epc;
    else if (stall_f)
      npc = pc_f;
    else if (dec_redirect)
      npc = dec_target;
    else if (state == PEND)
      npc = pend_target;
    else
      npc = pc_plus4_f;
  end

  // PC register and the RUN/PEND machine that owns the pending target.
  // Any unstalled cycle consumes or discards the pending entry. This covers
  // both using it and losing it to a live redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f        <= RESET_PC_AW;
      fetch_valid <= 1'b0;
      state       <= RUN;
      pend_target <= RESET_PC_AW;
    end else begin
      pc_f        <= npc;
      fetch_valid <= 1'b1;
      if (fetch_valid) begin
        if (exc_req || eret_req) begin
          state <= RUN;
        end else if (stall_f && dec_redirect) begin
          state       <= PEND;
          pend_target <= dec_target;
        end else if (!stall_f) begin
          state <= RUN;
        end
      end
    end
  end

endmodule
